// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller for an N-digit 7-segment display that
//   shares one BCD-to-7-segment decoder across all digits. Each digit is shown
//   for REFRESH_DIV cycles, optionally followed by BLANK_CYCLES cycles with all
//   anodes off to suppress ghosting. New values arrive over a valid/ready
//   handshake and are committed only at the frame boundary (wrap from the last
//   digit to digit 0), so a single frame never mixes old and new digits.
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        synchronous, active-high reset
//   load_valid_i   load_data_i is valid
//   load_data_i    BCD value, nibble i = digit i, digit 0 = LSD
//   load_ready_o   controller can accept a new value
//   lz_en_i        1 = blank leading zeros
//   bin_o          nibble driven to the shared decoder
//   an_o           one-hot digit enable, active-high, 0 = all off
//   frame_start_o  1-cycle pulse at the first SHOW cycle of digit 0
module display_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_valid_i,
    input  logic [4*N_DIGITS-1:0] load_data_i,
    output logic                  load_ready_o,
    input  logic                  lz_en_i,
    output logic [3:0]            bin_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  frame_start_o
);

    localparam int MAX_DB  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int MAX_CNT = (MAX_DB > 2) ? MAX_DB : 2;
    localparam int CNT_W   = $clog2(MAX_CNT);
    localparam int IDX_W   = $clog2(N_DIGITS);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } phase_e;

    phase_e                phase_q, phase_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] frame_q, frame_d;
    logic [4*N_DIGITS-1:0] pend_q, pend_d;
    logic                  pflag_q, pflag_d;

    logic                  advance;
    logic                  wrap;
    logic [N_DIGITS-1:0]   upper_zero;
    logic                  zero_run;
    logic                  lz_blank;

    // Ready is forced low during reset so nothing is captured while the
    // controller is being cleared.
    assign load_ready_o = !pflag_q && !reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= SHOW;
            idx_q   <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            pend_q  <= '0;
            pflag_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
        end
    end

    // Next-state: phase counter, digit advance, handshake and commit.
    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        frame_d = frame_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
        advance = 1'b0;
        wrap    = 1'b0;

        unique case (phase_q)
            SHOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (BLANK_CYCLES > 0) phase_d = BLANK;
                    else                  advance = 1'b1;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end
            end
            default: ;
        endcase

        if (advance) begin
            phase_d = SHOW;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Ready is low whenever a value is pending, so a commit and a new
        // transfer can never land in the same cycle.
        if (wrap && pflag_q) begin
            frame_d = pend_q;
            pflag_d = 1'b0;
        end else if (load_valid_i && load_ready_o) begin
            pend_d  = load_data_i;
            pflag_d = 1'b1;
        end
    end

    // Outputs decoded straight from state, no added latency.
    always_comb begin
        bin_o         = 4'd0;
        an_o          = '0;
        frame_start_o = 1'b0;
        upper_zero    = '0;
        zero_run      = 1'b1;

        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) bin_o = frame_q[4*i +: 4];
        end

        // upper_zero[i] = nibble i and every higher nibble are zero.
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (frame_q[4*i +: 4] == 4'd0);
            upper_zero[i] = zero_run;
        end

        lz_blank = lz_en_i && (idx_q != '0) && upper_zero[idx_q];

        if (!reset_i && (phase_q == SHOW) && !lz_blank)
            an_o = N_DIGITS'(1) << idx_q;

        frame_start_o = !reset_i && (phase_q == SHOW) && (idx_q == '0) && (cnt_q == '0);

        if (reset_i) bin_o = 4'd0;
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        lz_en = 1'b0;

    logic        a_ready, a_fs, b_ready, b_fs;
    logic [3:0]  a_bin, a_an, b_bin, b_an;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instance A: DIV=4, BLANK=1 (frame 20). Instance B: DIV=3, BLANK=0 (frame 12).
    display_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut_a (
        .clk_i(clk), .reset_i(reset), .load_valid_i(load_valid), .load_data_i(load_data),
        .load_ready_o(a_ready), .lz_en_i(lz_en), .bin_o(a_bin), .an_o(a_an),
        .frame_start_o(a_fs));

    display_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(3), .BLANK_CYCLES(0)) dut_b (
        .clk_i(clk), .reset_i(reset), .load_valid_i(load_valid), .load_data_i(load_data),
        .load_ready_o(b_ready), .lz_en_i(lz_en), .bin_o(b_bin), .an_o(b_an),
        .frame_start_o(b_fs));

    // Reference model: time since reset release, displayed value, pending value.
    localparam int DIVP [2] = '{4, 3};
    localparam int BLKP [2] = '{1, 0};
    int          m_t    [2];
    logic [15:0] m_disp [2];
    logic [15:0] m_pend [2];
    bit          m_pv   [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_t[k] = 0; m_disp[k] = '0; m_pv[k] = 1'b0;
            end else begin
                if ((((m_t[k] + 1) % (4 * (DIVP[k] + BLKP[k]))) == 0) && m_pv[k]) begin
                    m_disp[k] = m_pend[k]; m_pv[k] = 1'b0;
                end else if (load_valid && !m_pv[k]) begin
                    m_pend[k] = load_data; m_pv[k] = 1'b1;
                end
                m_t[k]++;
            end
        end
    end

    function automatic int m_digit(int k);
        int slot = DIVP[k] + BLKP[k];
        return (m_t[k] % (4 * slot)) / slot;
    endfunction

    function automatic bit m_show(int k);
        int slot = DIVP[k] + BLKP[k];
        return ((m_t[k] % (4 * slot)) % slot) < DIVP[k];
    endfunction

    function automatic logic [3:0] exp_an(int k);
        int d = m_digit(k);
        if (reset || !m_show(k)) return 4'b0;
        if (lz_en && d > 0 && (m_disp[k] >> (4 * d)) == 16'd0) return 4'b0;
        return 4'b1 << d;
    endfunction

    function automatic logic [3:0] exp_bin(int k);
        if (reset) return 4'd0;
        return 4'(m_disp[k] >> (4 * m_digit(k)));
    endfunction

    function automatic logic exp_fs(int k);
        return !reset && (m_t[k] % (4 * (DIVP[k] + BLKP[k])) == 0);
    endfunction

    function automatic logic exp_ready(int k);
        return !reset && !m_pv[k];
    endfunction

    // Leaves the bench at the negedge of cycle 0 after release.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; load_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; load_valid = 1'b0; lz_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (a_an !== 4'b0)  begin errors++; $display("FAIL reset_an_a got=%b exp=0000", a_an); end
        checks++; if (a_bin !== 4'd0) begin errors++; $display("FAIL reset_bin_a got=%h exp=0", a_bin); end
        checks++; if (a_fs !== 1'b0)  begin errors++; $display("FAIL reset_fs_a got=%b exp=0", a_fs); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_a got=%b exp=0", a_ready); end
        checks++; if (b_an !== 4'b0 || b_fs !== 1'b0 || b_ready !== 1'b0)
            begin errors++; $display("FAIL reset_b got an=%b fs=%b rdy=%b exp 0/0/0", b_an, b_fs, b_ready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (a_an !== 4'b0001 || a_fs !== 1'b1 || a_ready !== 1'b1 || a_bin !== 4'd0)
            begin errors++; $display("FAIL release_a got an=%b fs=%b rdy=%b bin=%h exp 0001/1/1/0", a_an, a_fs, a_ready, a_bin); end
    endtask

    task automatic test_scan_pattern();
        do_reset();
        for (int c = 0; c < 60; c++) begin
            int pos = c % 20;
            logic [3:0] ea;
            ea = (pos % 5 < 4) ? (4'b0001 << (pos / 5)) : 4'b0000;
            #1;
            checks++; if (a_an !== ea) begin errors++; $display("FAIL scan_an c=%0d got=%b exp=%b", c, a_an, ea); end
            checks++; if (a_fs !== (pos == 0)) begin errors++; $display("FAIL scan_fs c=%0d got=%b exp=%b", c, a_fs, pos == 0); end
            checks++; if (a_bin !== 4'd0) begin errors++; $display("FAIL scan_bin c=%0d got=%h exp=0", c, a_bin); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_commit();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            load_valid = (c == 7); load_data = 16'h1234;
            #1;
            if (c >= 8 && c < 20) begin
                checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL load_ready_low c=%0d got=%b exp=0", c, a_ready); end
            end
            if (c < 20) begin
                checks++; if (a_bin !== 4'd0) begin errors++; $display("FAIL load_bin_old c=%0d got=%h exp=0", c, a_bin); end
            end
            if (c == 20) begin
                checks++; if (a_an !== 4'b0001 || a_bin !== 4'd4 || a_ready !== 1'b1)
                    begin errors++; $display("FAIL load_commit got an=%b bin=%h rdy=%b exp 0001/4/1", a_an, a_bin, a_ready); end
            end
            if (c == 35) begin
                checks++; if (a_an !== 4'b1000 || a_bin !== 4'd1)
                    begin errors++; $display("FAIL load_digit3 got an=%b bin=%h exp 1000/1", a_an, a_bin); end
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 60; c++) begin
            load_valid = (c >= 7 && c <= 20);
            load_data  = (c == 7) ? 16'h1234 : 16'h5678;
            #1;
            if (c >= 8 && c < 20) begin
                checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold c=%0d got=%b exp=0", c, a_ready); end
            end
            if (c == 20) begin
                checks++; if (a_ready !== 1'b1 || a_bin !== 4'd4)
                    begin errors++; $display("FAIL b2b_commit1 got rdy=%b bin=%h exp 1/4", a_ready, a_bin); end
            end
            if (c == 21) begin
                checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got=%b exp=0", a_ready); end
            end
            if (c == 25) begin
                checks++; if (a_bin !== 4'd3) begin errors++; $display("FAIL b2b_frame1 got=%h exp=3", a_bin); end
            end
            if (c == 40) begin
                checks++; if (a_bin !== 4'd8 || a_an !== 4'b0001 || a_ready !== 1'b1)
                    begin errors++; $display("FAIL b2b_commit2 got bin=%h an=%b rdy=%b exp 8/0001/1", a_bin, a_an, a_ready); end
            end
            if (c == 55) begin
                checks++; if (a_bin !== 4'd5) begin errors++; $display("FAIL b2b_digit3 got=%h exp=5", a_bin); end
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
    endtask

    task automatic test_leading_zero();
        lz_en = 1'b1;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            int pos = c % 20;
            int d = pos / 5;
            bit show = (pos % 5) < 4;
            logic [3:0] ea, eb;
            load_valid = (c == 0); load_data = 16'h0050;
            if (c < 20) begin
                ea = (show && d == 0) ? 4'b0001 : 4'b0000;
                eb = 4'd0;
            end else begin
                ea = !show ? 4'b0000 : (d == 0) ? 4'b0001 : (d == 1) ? 4'b0010 : 4'b0000;
                eb = (d == 1) ? 4'd5 : 4'd0;
            end
            #1;
            checks++; if (a_an !== ea) begin errors++; $display("FAIL lz_an c=%0d got=%b exp=%b", c, a_an, ea); end
            checks++; if (a_bin !== eb) begin errors++; $display("FAIL lz_bin c=%0d got=%h exp=%h", c, a_bin, eb); end
            @(negedge clk);
        end
        load_valid = 1'b0; lz_en = 1'b0;
    endtask

    task automatic test_no_blank();
        do_reset();
        for (int c = 0; c < 36; c++) begin
            logic [3:0] ea;
            ea = 4'b0001 << ((c / 3) % 4);
            #1;
            checks++; if (b_an !== ea) begin errors++; $display("FAIL noblank_an c=%0d got=%b exp=%b", c, b_an, ea); end
            checks++; if (b_fs !== (c % 12 == 0)) begin errors++; $display("FAIL noblank_fs c=%0d got=%b exp=%b", c, b_fs, c % 12 == 0); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int c = 0; c < 53; c++) begin
            reset = (c == 11);
            load_valid = (c == 2); load_data = 16'h1234;
            #1;
            if (c == 11) begin
                checks++; if (a_an !== 4'b0 || a_bin !== 4'd0 || a_fs !== 1'b0 || a_ready !== 1'b0)
                    begin errors++; $display("FAIL midrst_hold got an=%b bin=%h fs=%b rdy=%b exp 0/0/0/0", a_an, a_bin, a_fs, a_ready); end
            end
            if (c == 12) begin
                checks++; if (a_an !== 4'b0001 || a_bin !== 4'd0 || a_fs !== 1'b1 || a_ready !== 1'b1)
                    begin errors++; $display("FAIL midrst_restart got an=%b bin=%h fs=%b rdy=%b exp 0001/0/1/1", a_an, a_bin, a_fs, a_ready); end
            end
            if (c > 12) begin
                checks++; if (a_bin !== 4'd0) begin errors++; $display("FAIL midrst_discard c=%0d got=%h exp=0", c, a_bin); end
            end
            @(negedge clk);
        end
        reset = 1'b0; load_valid = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            load_valid = ($urandom_range(0, 9) < 3);
            for (int n = 0; n < 4; n++)
                load_data[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
            #1;
            checks++; if (a_an !== exp_an(0)) begin errors++; $display("FAIL rand_an_a c=%0d got=%b exp=%b", c, a_an, exp_an(0)); end
            checks++; if (a_bin !== exp_bin(0)) begin errors++; $display("FAIL rand_bin_a c=%0d got=%h exp=%h", c, a_bin, exp_bin(0)); end
            checks++; if (a_fs !== exp_fs(0)) begin errors++; $display("FAIL rand_fs_a c=%0d got=%b exp=%b", c, a_fs, exp_fs(0)); end
            checks++; if (a_ready !== exp_ready(0)) begin errors++; $display("FAIL rand_ready_a c=%0d got=%b exp=%b", c, a_ready, exp_ready(0)); end
            checks++; if (b_an !== exp_an(1)) begin errors++; $display("FAIL rand_an_b c=%0d got=%b exp=%b", c, b_an, exp_an(1)); end
            checks++; if (b_bin !== exp_bin(1)) begin errors++; $display("FAIL rand_bin_b c=%0d got=%h exp=%h", c, b_bin, exp_bin(1)); end
            checks++; if (b_fs !== exp_fs(1)) begin errors++; $display("FAIL rand_fs_b c=%0d got=%b exp=%b", c, b_fs, exp_fs(1)); end
            checks++; if (b_ready !== exp_ready(1)) begin errors++; $display("FAIL rand_ready_b c=%0d got=%b exp=%b", c, b_ready, exp_ready(1)); end
            @(negedge clk);
        end
        reset = 1'b0; load_valid = 1'b0; lz_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_pattern();
        test_load_commit();
        test_back_to_back();
        test_leading_zero();
        test_no_blank();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
